// File: rtl/branch_sched_pkg.sv
// Shared types for the branch scheduler: op/result records, branch encodings
// and scheduler states.
package branch_sched_pkg;

  localparam logic [1:0] BR_EQ  = 2'd0;
  localparam logic [1:0] BR_LT  = 2'd1;
  localparam logic [1:0] BR_LTU = 2'd2;

  // Tag width carried in the records; the top-level TAG_W defaults to this.
  localparam int BR_TAG_W = 4;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [1:0]          br_type;
    logic                gate_sel;
    logic [31:0]         reg_a;
    logic [31:0]         reg_b;
    logic [31:0]         pc;
    logic [31:0]         imm;
    logic                pred_taken;
    logic [31:0]         pred_pc;
    logic [BR_TAG_W-1:0] tag;
  } branch_op_t;

  typedef struct packed {
    logic [BR_TAG_W-1:0] tag;
    logic                taken;
    logic [31:0]         next_pc;
    logic                mispredict;
  } branch_res_t;

  function automatic logic calc_mispredict(input logic taken, input logic [31:0] next_pc,
                                           input logic pred_taken, input logic [31:0] pred_pc);
    return (taken != pred_taken) || (next_pc != pred_pc);
  endfunction

endpackage

// File: rtl/branch_sched_fifo.sv
// Synchronous FIFO of branch ops; count disambiguates full/empty and the head
// reads as zero when empty.
module br_fifo
  import branch_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  branch_op_t               wr_data,
  output branch_op_t               rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  branch_op_t      mem_q [DEPTH];
  branch_op_t      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/branch_sched.sv
// In-order branch scheduler: queues dispatched branches, issues the head to the
// FU, holds the resolved result and raises a one-cycle redirect on mispredict.
//   state    | meaning
//   RUN      | normal queue/issue/result operation
//   REDIRECT | one-cycle redirect pulse to fetch; issue and accept blocked
module branch_sched
  import branch_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = BR_TAG_W
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_branch_type,
  input  logic                     in_gate_sel,
  input  logic [31:0]              in_reg_a,
  input  logic [31:0]              in_reg_b,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_imm,
  input  logic                     in_pred_taken,
  input  logic [31:0]              in_pred_pc,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     fu_branch,
  output logic [1:0]               fu_branch_type,
  output logic                     fu_branch_gate_sel,
  output logic [31:0]              fu_reg_a,
  output logic [31:0]              fu_reg_b,
  output logic [31:0]              fu_current_pc,
  output logic [31:0]              fu_imm,
  input  logic                     fu_branch_outcome,
  input  logic [31:0]              fu_updated_pc,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_taken,
  output logic [31:0]              res_next_pc,
  output logic                     res_mispredict,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  sched_state_e  state_q, state_d;
  branch_res_t   res_q, res_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;

  branch_op_t    in_op, head;
  logic [CW-1:0] occ;
  logic          hs, mis_hs, issue, push, fifo_clear;

  always_comb begin
    in_op.br_type    = in_branch_type;
    in_op.gate_sel   = in_gate_sel;
    in_op.reg_a      = in_reg_a;
    in_op.reg_b      = in_reg_b;
    in_op.pc         = in_pc;
    in_op.imm        = in_imm;
    in_op.pred_taken = in_pred_taken;
    in_op.pred_pc    = in_pred_pc;
    in_op.tag        = BR_TAG_W'(in_tag);
  end

  br_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (nRST),
    .clear   (fifo_clear),
    .push    (push),
    .pop     (issue),
    .wr_data (in_op),
    .rd_data (head),
    .count   (occ)
  );

  always_comb begin
    hs     = res_valid_q && res_ready;
    mis_hs = hs && res_q.mispredict && (state_q == RUN);
    // Everything still queued behind a mispredicted branch is wrong-path.
    issue  = (occ != '0) && (state_q == RUN) && (!res_valid_q || res_ready) && !mis_hs;
    in_ready   = ((occ != FULL) || issue) && (state_q == RUN) && !flush;
    push       = in_valid && in_ready;
    fifo_clear = flush || mis_hs;
  end

  always_comb begin
    state_d       = RUN;
    res_d         = res_q;
    res_valid_d   = res_valid_q;
    redirect_pc_d = redirect_pc_q;
    if (hs) begin
      res_valid_d = 1'b0;
    end
    if (issue) begin
      res_valid_d        = 1'b1;
      res_d.tag          = head.tag;
      res_d.taken        = fu_branch_outcome;
      res_d.next_pc      = fu_updated_pc;
      res_d.mispredict   = calc_mispredict(fu_branch_outcome, fu_updated_pc,
                                           head.pred_taken, head.pred_pc);
    end
    if (mis_hs) begin
      state_d       = REDIRECT;
      redirect_pc_d = res_q.next_pc;
    end
    if (flush) begin
      state_d     = RUN;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q       <= RUN;
      res_q         <= '0;
      res_valid_q   <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      res_q         <= res_d;
      res_valid_q   <= res_valid_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign fu_branch          = issue;
  assign fu_branch_type     = head.br_type;
  assign fu_branch_gate_sel = head.gate_sel;
  assign fu_reg_a           = head.reg_a;
  assign fu_reg_b           = head.reg_b;
  assign fu_current_pc      = head.pc;
  assign fu_imm             = head.imm;

  assign res_valid      = res_valid_q;
  assign res_tag        = TAG_W'(res_q.tag);
  assign res_taken      = res_q.taken;
  assign res_next_pc    = res_q.next_pc;
  assign res_mispredict = res_q.mispredict;
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign occupancy      = occ;

endmodule

// File: tb/tb_branch_sched.sv
// Scoreboard bench for branch_sched with a behavioural branch FU model.
module tb_branch_sched;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_branch_type = '0;
  logic        in_gate_sel = 1'b0;
  logic [31:0] in_reg_a = '0, in_reg_b = '0, in_pc = '0, in_imm = '0, in_pred_pc = '0;
  logic        in_pred_taken = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        fu_branch, fu_branch_gate_sel, fu_branch_outcome;
  logic [1:0]  fu_branch_type;
  logic [31:0] fu_reg_a, fu_reg_b, fu_current_pc, fu_imm, fu_updated_pc;
  logic        res_valid, res_taken, res_mispredict;
  logic        res_ready = 1'b1;
  logic [3:0]  res_tag;
  logic [31:0] res_next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  logic [37:0] sb[$];
  logic        mon_en = 1'b0;
  logic        rd_exp = 1'b0;
  logic [31:0] rd_exp_pc = '0;

  branch_sched #(.DEPTH(4), .TAG_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_branch_type(in_branch_type), .in_gate_sel(in_gate_sel),
    .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_pc(in_pred_pc), .in_tag(in_tag),
    .fu_branch(fu_branch), .fu_branch_type(fu_branch_type),
    .fu_branch_gate_sel(fu_branch_gate_sel),
    .fu_reg_a(fu_reg_a), .fu_reg_b(fu_reg_b), .fu_current_pc(fu_current_pc), .fu_imm(fu_imm),
    .fu_branch_outcome(fu_branch_outcome), .fu_updated_pc(fu_updated_pc),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_taken(res_taken), .res_next_pc(res_next_pc), .res_mispredict(res_mispredict),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  // Branch FU: zero flag of the compare selects taken via gate_sel.
  always_comb begin
    logic cond;
    case (fu_branch_type)
      2'd0:    cond = (fu_reg_a != fu_reg_b);
      2'd1:    cond = ($signed(fu_reg_a) < $signed(fu_reg_b));
      default: cond = (fu_reg_a < fu_reg_b);
    endcase
    fu_branch_outcome = fu_branch_gate_sel ? cond : !cond;
    fu_updated_pc     = fu_branch_outcome ? (fu_current_pc + fu_imm) : (fu_current_pc + 32'd4);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result/redirect monitor.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (rd_exp) begin
        chk("redirect_valid", {63'd0, redirect_valid}, 64'd1);
        chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, rd_exp_pc});
      end else begin
        chk("redirect_idle", {63'd0, redirect_valid}, 64'd0);
      end
      rd_exp = 1'b0;
      if (res_valid && res_ready && !nRST) begin
        chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          logic [37:0] e;
          e = sb.pop_front();
          chk("result", {26'd0, res_tag, res_taken, res_next_pc, res_mispredict}, {26'd0, e});
          if (e[0] && !flush) begin
            rd_exp    = 1'b1;
            rd_exp_pc = e[32:1];
            sb.delete();
          end
        end
      end
    end
  end

  task automatic push_op(input logic [1:0] ty, input logic gs, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                         input logic [31:0] ppc, input logic [3:0] tag,
                         input logic et, input logic [31:0] enpc);
    logic acc;
    in_valid = 1'b1; in_branch_type = ty; in_gate_sel = gs; in_reg_a = a; in_reg_b = b;
    in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_pc = ppc; in_tag = tag;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        acc = 1'b1;
        sb.push_back({tag, et, enpc, (et != pt) || (enpc != ppc)});
      end
      @(posedge CLK); #1;
    end
    chk("accept", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    idle(2);
    @(negedge CLK);
    chk("rst_occ", {61'd0, occupancy}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_redirect", {63'd0, redirect_valid}, 64'd0);
    chk("rst_fu_branch", {63'd0, fu_branch}, 64'd0);
    chk("rst_res_pc", {32'd0, res_next_pc}, 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b0;
    mon_en = 1'b1;

    // Correctly predicted BEQ and its two-cycle latency.
    push_op(2'd0, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120, 4'd1, 1'b1, 32'h120);
    @(negedge CLK);
    chk("lat_not_yet", {63'd0, res_valid}, 64'd0);
    chk("lat_issue", {63'd0, fu_branch}, 64'd1);
    chk("lat_fu_pc", {32'd0, fu_current_pc}, 64'h100);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("lat_valid", {63'd0, res_valid}, 64'd1);
    idle(3);

    // Mispredicted BLT with a younger op queued behind it.
    res_ready = 1'b0;
    push_op(2'd1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 32'h204, 4'd2, 1'b1, 32'h240);
    push_op(2'd0, 1'b0, 32'd1, 32'd1, 32'h240, 32'h8, 1'b1, 32'h248, 4'd3, 1'b1, 32'h248);
    @(negedge CLK);
    chk("mis_occ_pre", {61'd0, occupancy}, 64'd1);
    chk("mis_res_held", {63'd0, res_valid}, 64'd1);
    @(posedge CLK); #1;
    res_ready = 1'b1;
    @(negedge CLK);
    chk("mis_issue_blocked", {63'd0, fu_branch}, 64'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mis_occ_cleared", {61'd0, occupancy}, 64'd0);
    chk("mis_in_ready", {63'd0, in_ready}, 64'd0);
    chk("mis_res_cleared", {63'd0, res_valid}, 64'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mis_back_to_run", {63'd0, in_ready}, 64'd1);
    @(posedge CLK); #1;

    // Fill with the result register stalled, then drain back-to-back.
    res_ready = 1'b0;
    for (int t = 4; t < 9; t++)
      push_op(2'd0, 1'b0, 32'(t), 32'(t), 32'h1000 + 32'(t) * 32'h10, 32'h80, 1'b1,
              32'h1080 + 32'(t) * 32'h10, 4'(t), 1'b1, 32'h1080 + 32'(t) * 32'h10);
    @(negedge CLK);
    chk("full_occ", {61'd0, occupancy}, 64'd4);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge CLK); #1;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("drain_valid", {63'd0, res_valid}, 64'd1);
      chk("drain_occ", {61'd0, occupancy}, 64'(4 - k));
      if (k == 0) chk("full_pop_accept", {63'd0, in_ready}, 64'd1);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("drain_done", {63'd0, res_valid}, 64'd0);
    @(posedge CLK); #1;

    // BLTU, unsigned compare not taken, correctly predicted.
    push_op(2'd2, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 1'b0, 32'h304, 4'd9, 1'b0, 32'h304);
    idle(4);

    // Flush with three queued and a held result.
    res_ready = 1'b0;
    for (int t = 10; t < 14; t++)
      push_op(2'd0, 1'b0, 32'd0, 32'd0, 32'h500 + 32'(t), 32'h4, 1'b1, 32'h504 + 32'(t), 4'(t),
              1'b1, 32'h504 + 32'(t));
    @(negedge CLK);
    chk("flush_pre_occ", {61'd0, occupancy}, 64'd3);
    chk("flush_pre_res", {63'd0, res_valid}, 64'd1);
    @(posedge CLK); #1;
    flush = 1'b1;
    @(negedge CLK);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge CLK); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge CLK);
    chk("flush_occ", {61'd0, occupancy}, 64'd0);
    chk("flush_res", {63'd0, res_valid}, 64'd0);
    chk("flush_redirect", {63'd0, redirect_valid}, 64'd0);
    @(posedge CLK); #1;
    res_ready = 1'b1;

    // Reset arriving during the redirect pulse.
    push_op(2'd1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h40, 1'b0, 32'h404, 4'd14, 1'b1, 32'h440);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (redirect_valid) seen = 1'b1;
      else begin
        @(posedge CLK); #1;
      end
    end
    chk("rd_seen", {63'd0, seen}, 64'd1);
    nRST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstr_redirect", {63'd0, redirect_valid}, 64'd0);
    chk("rstr_redirect_pc", {32'd0, redirect_pc}, 64'd0);
    chk("rstr_occ", {61'd0, occupancy}, 64'd0);
    chk("rstr_res", {26'd0, res_valid, res_tag, res_taken, res_next_pc}, 64'd0);
    chk("rstr_mis", {63'd0, res_mispredict}, 64'd0);
    chk("rstr_fu", {fu_branch, fu_branch_gate_sel, fu_branch_type, fu_reg_a[27:0], fu_current_pc}, 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b0;
    idle(3);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
